// File: rtl/proc_control_unit_if.sv
// Control bundle between the processor control unit and the fetch path / datapath.
// The controller drives every strobe and address field and reads back only the instruction word.
interface proc_control_unit_if #(
    parameter int IW  = 16,
    parameter int DAW = 8,
    parameter int RAW = 4
);
    logic [IW-1:0]  IR;
    logic           PC_clr;
    logic           PC_up;
    logic           IR_ld;
    logic [DAW-1:0] D_addr;
    logic           D_wr;
    logic           RF_s;
    logic [RAW-1:0] RF_W_addr;
    logic           RF_W_wr;
    logic [RAW-1:0] RF_Ra_addr;
    logic           RF_Ra_rd;
    logic [RAW-1:0] RF_Rb_addr;
    logic           RF_Rb_rd;
    logic [2:0]     ALU_s0;
    logic [3:0]     State;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld,
        output D_addr, D_wr,
        output RF_s, RF_W_addr, RF_W_wr,
        output RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd,
        output ALU_s0, State
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld,
        input  D_addr, D_wr,
        input  RF_s, RF_W_addr, RF_W_wr,
        input  RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd,
        input  ALU_s0, State
    );
endinterface

// File: rtl/proc_control_unit.sv
// Moore fetch/decode/execute sequencer for the 16-bit processor.
//
// state  | meaning
// INIT   | clear PC after reset
// FETCH  | load IR from ROM, advance PC
// DECODE | IR valid, branch on opcode
// NOOP   | no operation (also illegal opcodes)
// LOAD_A | present memory address, wait for read data
// LOAD_B | write memory read data into register file
// STORE  | write register Ra into data memory
// ADD    | Rw <= Ra + Rb
// SUB    | Rw <= Ra - Rb
// HALT   | frozen until reset
module proc_control_unit #(
    parameter int IW  = 16,
    parameter int DAW = 8,
    parameter int RAW = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    proc_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    state_t         state_q;
    logic [3:0]     opcode;
    logic [DAW-1:0] mem_addr;
    logic [RAW-1:0] dst_addr;
    logic [RAW-1:0] src_a_addr;
    logic [RAW-1:0] src_b_addr;

    assign opcode     = bus.IR[IW-1:IW-4];
    assign mem_addr   = bus.IR[DAW+RAW-1:RAW];
    assign dst_addr   = bus.IR[RAW-1:0];
    assign src_a_addr = bus.IR[3*RAW-1:2*RAW];
    assign src_b_addr = bus.IR[2*RAW-1:RAW];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= INIT;
        end else begin
            case (state_q)
                INIT:   state_q <= FETCH;
                FETCH:  state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        4'b0001: state_q <= STORE;
                        4'b0010: state_q <= LOAD_A;
                        4'b0011: state_q <= ADD;
                        4'b0100: state_q <= SUB;
                        4'b0101: state_q <= HALT;
                        default: state_q <= NOOP;
                    endcase
                end
                NOOP:   state_q <= FETCH;
                LOAD_A: state_q <= LOAD_B;
                LOAD_B: state_q <= FETCH;
                STORE:  state_q <= FETCH;
                ADD:    state_q <= FETCH;
                SUB:    state_q <= FETCH;
                HALT:   state_q <= HALT;
                default: state_q <= INIT;
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset
    // kills any write enable before the next clock edge.
    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_wr    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Ra_rd   = 1'b0;
        bus.RF_Rb_addr = '0;
        bus.RF_Rb_rd   = 1'b0;
        bus.ALU_s0     = ALU_PASS;
        case (state_q)
            INIT: begin
                bus.PC_clr = 1'b1;
            end
            FETCH: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
            end
            LOAD_A: begin
                bus.D_addr    = mem_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = dst_addr;
            end
            LOAD_B: begin
                bus.D_addr    = mem_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = dst_addr;
                bus.RF_W_wr   = 1'b1;
            end
            STORE: begin
                bus.D_addr     = mem_addr;
                bus.RF_Ra_addr = dst_addr;
                bus.RF_Ra_rd   = 1'b1;
                bus.D_wr       = 1'b1;
            end
            ADD, SUB: begin
                bus.RF_Ra_addr = src_a_addr;
                bus.RF_Rb_addr = src_b_addr;
                bus.RF_Ra_rd   = 1'b1;
                bus.RF_Rb_rd   = 1'b1;
                bus.ALU_s0     = (state_q == ADD) ? ALU_ADD : ALU_SUB;
                bus.RF_s       = 1'b0;
                bus.RF_W_addr  = dst_addr;
                bus.RF_W_wr    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.State = state_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: per-cycle expected control words are
// queued from an instruction-level model and compared by an independent monitor.
module tb_proc_control_unit;

    logic Clk;
    logic Reset_n;

    proc_control_unit_if #(.IW(16), .DAW(8), .RAW(4)) bus ();

    proc_control_unit #(.IW(16), .DAW(8), .RAW(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.master)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_wr;
        logic [3:0] ra_addr;
        logic       ra_rd;
        logic [3:0] rb_addr;
        logic       rb_rd;
        logic [2:0] alu;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t mon_exp;
    exp_t mon_act;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Monitor: every falling edge with an outstanding expectation is compared.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            mon_exp         = exp_q.pop_front();
            mon_act         = '0;
            mon_act.st      = bus.State;
            mon_act.pc_clr  = bus.PC_clr;
            mon_act.pc_up   = bus.PC_up;
            mon_act.ir_ld   = bus.IR_ld;
            mon_act.d_addr  = bus.D_addr;
            mon_act.d_wr    = bus.D_wr;
            mon_act.rf_s    = bus.RF_s;
            mon_act.w_addr  = bus.RF_W_addr;
            mon_act.w_wr    = bus.RF_W_wr;
            mon_act.ra_addr = bus.RF_Ra_addr;
            mon_act.ra_rd   = bus.RF_Ra_rd;
            mon_act.rb_addr = bus.RF_Rb_addr;
            mon_act.rb_rd   = bus.RF_Rb_rd;
            mon_act.alu     = bus.ALU_s0;
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL cycle_word t=%0t IR=%h actual=%h required=%h (state act=%0d req=%0d)",
                         $time, bus.IR, mon_act, mon_exp, mon_act.st, mon_exp.st);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic exp_t init_word();
        exp_t e = '0;
        e.pc_clr = 1'b1;
        return e;
    endfunction

    // Instruction-level model: the sequence of control words one instruction produces,
    // starting with its FETCH cycle. Returns the number of cycles queued.
    task automatic push_instr(input logic [15:0] ir, output int n);
        exp_t e;
        logic [3:0] op;
        op = ir[15:12];
        e = '0; e.st = 4'd1; e.pc_up = 1'b1; e.ir_ld = 1'b1;
        exp_q.push_back(e);
        e = '0; e.st = 4'd2;
        exp_q.push_back(e);
        n = 2;
        e = '0;
        case (op)
            4'd1: begin
                e.st = 4'd6; e.d_addr = ir[11:4]; e.ra_addr = ir[3:0];
                e.ra_rd = 1'b1; e.d_wr = 1'b1;
                exp_q.push_back(e); n += 1;
            end
            4'd2: begin
                e.st = 4'd4; e.d_addr = ir[11:4]; e.rf_s = 1'b1; e.w_addr = ir[3:0];
                exp_q.push_back(e);
                e.st = 4'd5; e.w_wr = 1'b1;
                exp_q.push_back(e); n += 2;
            end
            4'd3, 4'd4: begin
                e.st = (op == 4'd3) ? 4'd7 : 4'd8;
                e.ra_addr = ir[11:8]; e.rb_addr = ir[7:4];
                e.ra_rd = 1'b1; e.rb_rd = 1'b1;
                e.alu = (op == 4'd3) ? 3'b001 : 3'b010;
                e.w_addr = ir[3:0]; e.w_wr = 1'b1;
                exp_q.push_back(e); n += 1;
            end
            4'd5: begin
                e.st = 4'd9;
                repeat (50) exp_q.push_back(e);
                n += 50;
            end
            default: begin
                e.st = 4'd3;
                exp_q.push_back(e); n += 1;
            end
        endcase
    endtask

    // Hold reset for n falling edges, release, and leave the bench at the
    // start of the first FETCH cycle (INIT lasts exactly one cycle).
    task automatic do_reset(input int n);
        Reset_n = 1'b0;
        repeat (n) begin
            exp_q.push_back(init_word());
            @(negedge Clk);
            #1;
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        exp_q.push_back(init_word());
        @(posedge Clk);
        #1;
    endtask

    // Issue one instruction from the start of its FETCH cycle; HALT ends with a reset pulse.
    task automatic run_instr(input logic [15:0] ir);
        int n;
        bus.IR = ir;
        push_instr(ir, n);
        repeat (n) @(posedge Clk);
        #1;
        if (ir[15:12] == 4'd5) begin
            chk("halt_hold_state", 32'(bus.State), 32'd9);
            chk("halt_pc_up", 32'(bus.PC_up), 32'd0);
            #1;
            Reset_n = 1'b0;
            #1;
            chk("halt_reset_state", 32'(bus.State), 32'd0);
            do_reset(1);
        end
    endtask

    initial begin
        logic [15:0] ir;
        Reset_n = 1'b1;
        bus.IR  = 16'h0000;
        #1;
        do_reset(3);

        run_instr(16'h3124);
        run_instr(16'h21A3);
        run_instr(16'h1055);
        run_instr(16'hF000);
        run_instr(16'h4BCD);
        run_instr(16'h0000);

        // Reset asserted in the middle of an ADD must drop the write enable immediately.
        begin
            exp_t e;
            bus.IR = 16'h3567;
            e = '0; e.st = 4'd1; e.pc_up = 1'b1; e.ir_ld = 1'b1;
            exp_q.push_back(e);
            e = '0; e.st = 4'd2;
            exp_q.push_back(e);
            repeat (2) @(posedge Clk);
            #1;
            chk("add_state_before_reset", 32'(bus.State), 32'd7);
            chk("add_wr_before_reset", 32'(bus.RF_W_wr), 32'd1);
            Reset_n = 1'b0;
            #1;
            chk("add_wr_after_reset", 32'(bus.RF_W_wr), 32'd0);
            chk("add_state_after_reset", 32'(bus.State), 32'd0);
            do_reset(2);
        end

        run_instr(16'h5000);

        for (int i = 0; i < 60; i++) begin
            ir = 16'($urandom);
            ir[15:12] = 4'($urandom_range(0, 15));
            run_instr(ir);
        end

        run_instr(16'h2FF0);
        run_instr(16'h5ABC);
        run_instr(16'h1FFF);

        @(negedge Clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Moore-style FSM control unit for the 16-bit processor.
- Sequences the program counter, instruction register, data memory, register file and ALU through fetch/decode/execute.
- Drives the PC's Clr/Up inputs and decodes IR[15:12] to generate per-instruction control strobes.
- Sits between the instruction-fetch path (PC + instruction ROM + IR) and the datapath (RAM, register file, ALU).

Parameters:
- IW, 16, instruction width; opcode is IR[IW-1:IW-4].
- DAW, 8, data memory address width.
- RAW, 4, register file address width.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- IR  in  IW  current instruction from the instruction register.
- PC_clr  out  1  clear program counter.
- PC_up  out  1  increment program counter.
- IR_ld  out  1  load instruction register from ROM.
- D_addr  out  DAW  data memory address.
- D_wr  out  1  data memory write enable.
- RF_s  out  1  register file write-source select: 0 = ALU result, 1 = memory read data.
- RF_W_addr  out  RAW  register file write address.
- RF_W_wr  out  1  register file write enable.
- RF_Ra_addr  out  RAW  read port A address.
- RF_Ra_rd  out  1  read port A enable.
- RF_Rb_addr  out  RAW  read port B address.
- RF_Rb_rd  out  1  read port B enable.
- ALU_s0  out  3  ALU function: 000 pass A, 001 add, 010 sub.
- State  out  4  current state encoding, for debug.

Behaviour:
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Single state register, async cleared to INIT when Reset_n=0. All outputs are decoded combinationally from State and IR only; no input-to-output path bypasses State except IR fields.
- Default for every output in every state: 0. Only the strobes listed per state are asserted.
- During reset and in the first cycle after release: State=INIT, PC_clr=1, all else 0.
- INIT: PC_clr=1 -> FETCH.
- FETCH: IR_ld=1, PC_up=1 -> DECODE. IR is valid from DECODE onward.
- DECODE: no strobes. Next state by opcode IR[15:12]:
  - 0000 -> NOOP
  - 0001 -> STORE
  - 0010 -> LOAD_A
  - 0011 -> ADD
  - 0100 -> SUB
  - 0101 -> HALT
  - 0110-1111 -> NOOP (illegal opcodes are treated as NOOP, never a hang).
- NOOP: -> FETCH.
- LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0] -> LOAD_B (memory read latency is 1 cycle).
- LOAD_B: D_addr, RF_s and RF_W_addr held as in LOAD_A; RF_W_wr=1 -> FETCH.
- STORE: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], RF_Ra_rd=1, D_wr=1 -> FETCH.
- ADD: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_Ra_rd=RF_Rb_rd=1, ALU_s0=001, RF_s=0, RF_W_addr=IR[3:0], RF_W_wr=1 -> FETCH.
- SUB: same as ADD with ALU_s0=010.
- HALT: all strobes 0; stays in HALT until Reset_n asserted. PC_up is never asserted in HALT, so the PC freezes.
- Instruction latencies (cycles from FETCH to the next FETCH):
  - NOOP, STORE, ADD, SUB: 3.
  - LOAD: 4.
  - First FETCH occurs 2 cycles after reset release (INIT is one cycle).
- PC wrap (127 -> 0) is owned by the PC. The controller asserts PC_up exactly once per instruction regardless of address.
- Reset mid-instruction (any state) forces INIT asynchronously. Any in-progress D_wr/RF_W_wr deasserts immediately and no partial write is issued on the following edge.
- Address fields are zero-width-extended by slicing only; no arithmetic is performed in this block.
- Unreachable state encodings (10-15) -> INIT on the next edge.

Test Plan:
- Reset held low 3 cycles, then released -> State=0 with PC_clr=1. Next edge: State=1 with IR_ld=1 and PC_up=1. Next: State=2.
- IR=16'h3124 (ADD) after FETCH -> in state 7: RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=4, ALU_s0=001, RF_W_wr=1, RF_s=0. Next state FETCH. PC_up pulsed once in 3 cycles.
- IR=16'h21A3 (LOAD) -> LOAD_A then LOAD_B with D_addr=8'h1A, RF_s=1, RF_W_addr=3. RF_W_wr=1 only in LOAD_B. 4 cycles FETCH-to-FETCH.
- IR=16'h1055 (STORE) -> state 6: D_addr=8'h05, RF_Ra_addr=5, RF_Ra_rd=1, D_wr=1 for exactly one cycle.
- IR=16'h5000 (HALT) -> State=9 held for 50 cycles with PC_up=0 throughout. Reset_n pulse -> INIT.
- IR=16'hF000 (illegal) -> NOOP then FETCH. Separately, Reset_n dropped during ADD -> RF_W_wr falls in the same cycle, before the clock edge, and State=0.
